// File: rtl/sp_usb_pkg.sv
// Shared definitions for the USB FIFO bridge: FSM states and the direction
// encoding used by the read/write fairness arbiter.
package sp_usb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD      = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    typedef logic dir_t;

    localparam dir_t DIR_RD = 1'b0;
    localparam dir_t DIR_WR = 1'b1;

endpackage

// File: rtl/sp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy.
// Head word is visible on dout_o whenever empty_o is low; a push while full
// and a pop while empty are ignored, so push+pop together is always legal.
module sp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      level_o
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LEVEL);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Occupancy follows accepted pushes and pops only.
    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally (DEPTH = 2^AW).
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sp_usb_fifo_bridge.sv
// Bridge between an 8-bit FT245-style USB FIFO chip and WIDTH-bit kernel
// streams. Words are sent and received as little-endian byte sequences; a
// one-cycle strobe is followed by a one-cycle recovery, and the direction
// alternates whenever both sides have work.
module sp_usb_fifo_bridge
    import sp_usb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [7:0]       usb_data,
    input  logic             rxf_n,
    input  logic             txe_n,
    output logic             rd_n,
    output logic             wr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             write,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    input  logic             read,
    output logic             avail,
    output logic [LW-1:0]    tx_level,
    output logic [LW-1:0]    rx_level
);

    localparam int BYTES = WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(BYTES - 1);

    state_t           state_q;
    state_t           state_d;
    dir_t             last_dir_q;
    logic [BW-1:0]    tx_idx_q;
    logic [BW-1:0]    rx_idx_q;
    logic [7:0]       wr_byte_q;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] rx_word;

    logic [WIDTH-1:0] tx_head;
    logic             tx_empty;
    logic             tx_full;
    logic             tx_pop;
    logic             rx_empty;
    logic             rx_full;
    logic             rx_push;

    logic             tx_ok;
    logic             rx_ok;
    logic             bus_drive;

    // Host-to-chip direction: kernel pushes words, serializer pops them.
    sp_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (write),
        .din_i   (din),
        .pop_i   (tx_pop),
        .dout_o  (tx_head),
        .empty_o (tx_empty),
        .full_o  (tx_full),
        .level_o (tx_level)
    );

    // Chip-to-host direction: deserializer pushes words, kernel pops them.
    sp_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .din_i   (rx_word),
        .pop_i   (read),
        .dout_o  (dout),
        .empty_o (rx_empty),
        .full_o  (rx_full),
        .level_o (rx_level)
    );

    assign full  = tx_full;
    assign avail = !rx_empty;

    // A byte is only fetched while a whole RX slot is free, so a completed
    // word can always be pushed without a drop.
    assign tx_ok = !tx_empty && !txe_n;
    assign rx_ok = !rxf_n && !rx_full;

    assign tx_pop  = (state_q == ST_WR) && (tx_idx_q == LAST_IDX);
    assign rx_push = (state_q == ST_RD) && (rx_idx_q == LAST_IDX);

    // Assembled word with the byte currently on the bus merged into its lane,
    // so the final byte and the push happen on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_rx_lane
            assign rx_word[8*gi +: 8] = (rx_idx_q == BW'(gi)) ? usb_data : asm_q[8*gi +: 8];
        end
    endgenerate

    assign usb_data = bus_drive ? wr_byte_q : 8'bzzzz_zzzz;

    // State register and fairness memory (last direction served).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            last_dir_q <= DIR_RD;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_WR) begin
                last_dir_q <= DIR_WR;
            end else if (state_q == ST_IDLE && state_d == ST_RD) begin
                last_dir_q <= DIR_RD;
            end
        end
    end

    // Next-state: on a tie the direction not served last time wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_ok && (!rx_ok || last_dir_q == DIR_RD)) begin
                    state_d = ST_WR;
                end else if (rx_ok && (!tx_ok || last_dir_q == DIR_WR)) begin
                    state_d = ST_RD;
                end
            end
            ST_WR:      state_d = ST_RECOVER;
            ST_RD:      state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Strobes and bus enable decoded from the current state.
    always_comb begin
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        bus_drive = 1'b0;
        case (state_q)
            ST_WR: begin
                wr_n      = 1'b0;
                bus_drive = 1'b1;
            end
            ST_RD: begin
                rd_n = 1'b0;
            end
            default: begin
                rd_n      = 1'b1;
                wr_n      = 1'b1;
                bus_drive = 1'b0;
            end
        endcase
    end

    // Byte serializer / deserializer: lane indices, outgoing byte, assembly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_idx_q  <= '0;
            rx_idx_q  <= '0;
            wr_byte_q <= '0;
            asm_q     <= '0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_WR) begin
                wr_byte_q <= tx_head[8*tx_idx_q +: 8];
            end
            if (state_q == ST_WR) begin
                tx_idx_q <= (tx_idx_q == LAST_IDX) ? '0 : tx_idx_q + 1'b1;
            end
            if (state_q == ST_RD) begin
                asm_q    <= rx_word;
                rx_idx_q <= (rx_idx_q == LAST_IDX) ? '0 : rx_idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sp_usb_fifo_bridge.sv
// Bench for sp_usb_fifo_bridge: a byte-level chip model plus scoreboards of
// expected TX bytes and RX words, checked by an independent monitor.
module tb_sp_usb_fifo_bridge;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int BYTES = WIDTH / 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    wire  [7:0]       usb_data;
    logic             rxf_n = 1'b1;
    logic             txe_n = 1'b1;
    logic             rd_n;
    logic             wr_n;
    logic [WIDTH-1:0] din   = '0;
    logic             write = 1'b0;
    logic             full;
    logic [WIDTH-1:0] dout;
    logic             read  = 1'b0;
    logic             avail;
    logic [LW-1:0]    tx_level;
    logic [LW-1:0]    rx_level;

    int n_vec = 0;
    int n_err = 0;

    // Chip model state
    logic [7:0] chip_q[$];
    logic [7:0] chip_byte = 8'h00;
    logic       rd_pend   = 1'b0;
    logic       rx_en     = 1'b0;

    // Scoreboards
    logic [7:0]       exp_tx[$];
    logic [WIDTH-1:0] exp_rx[$];

    // Monitor bookkeeping
    int         cyc           = 0;
    int         last_strobe   = -100;
    int         last_rd_cyc   = -100;
    int         rd_cnt        = 0;
    int         tx_bytes_seen = 0;
    int         tx_words_done = 0;
    int         tx_words_acc  = 0;
    int         wr_cycs[$];
    logic [7:0] strobe_log[$];
    logic       log_en = 1'b0;

    assign usb_data = (!rd_n) ? chip_byte : 8'bzzzz_zzzz;

    sp_usb_fifo_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .usb_data (usb_data),
        .rxf_n    (rxf_n),
        .txe_n    (txe_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .din      (din),
        .write    (write),
        .full     (full),
        .dout     (dout),
        .read     (read),
        .avail    (avail),
        .tx_level (tx_level),
        .rx_level (rx_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_rx_word(input logic [WIDTH-1:0] w);
        for (int b = 0; b < BYTES; b++) chip_q.push_back(w[8*b +: 8]);
        exp_rx.push_back(w);
    endtask

    task automatic push_tx_word(input logic [WIDTH-1:0] w);
        for (int b = 0; b < BYTES; b++) exp_tx.push_back(w[8*b +: 8]);
    endtask

    // Run both directions until every expected byte/word has been seen.
    task automatic drain(input int budget);
        write = 1'b0;
        txe_n = 1'b0;
        rx_en = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (exp_tx.size() == 0 && exp_rx.size() == 0 && chip_q.size() == 0) break;
            read = avail;
            @(negedge clk);
        end
        read = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain_tx_empty", 32'(exp_tx.size()), 0);
        chk("drain_rx_empty", 32'(exp_rx.size()), 0);
        chk("drain_avail", 32'(avail), 0);
        chk("drain_tx_level", 32'(tx_level), 0);
        chk("drain_rx_level", 32'(rx_level), 0);
    endtask

    // Chip model: presents its head byte while rd_n is low, consumes it after the strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_pend && chip_q.size() > 0) void'(chip_q.pop_front());
            rd_pend   = !rd_n;
            chip_byte = (chip_q.size() > 0) ? chip_q[0] : 8'h00;
            rxf_n     = !(rx_en && chip_q.size() > 0);
        end
    end

    // Monitor: checks every strobe and every word the kernel pops.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!wr_n || !rd_n) begin
                chk("strobe_exclusive", 32'(wr_n | rd_n), 1);
                chk("strobe_gap_ge3", 32'((cyc - last_strobe) >= 3), 1);
                last_strobe = cyc;
            end
            if (!wr_n) begin
                wr_cycs.push_back(cyc);
                if (log_en) strobe_log.push_back(8'h57);
                if (exp_tx.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_spurious_byte: got 0x%0h with no byte expected", usb_data);
                end else begin
                    chk("tx_byte", 32'(usb_data), 32'(exp_tx.pop_front()));
                    tx_bytes_seen++;
                    if (tx_bytes_seen % BYTES == 0) tx_words_done++;
                end
            end
            if (!rd_n) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (log_en) strobe_log.push_back(8'h52);
            end
            if (read && avail) begin
                if (exp_rx.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_spurious_word: got 0x%0h with no word expected", dout);
                end else begin
                    chk("rx_word", dout, exp_rx.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        logic [WIDTH-1:0] w;

        // Reset held for 3 cycles while the kernel side is active.
        rst   = 1'b0;
        write = 1'b1;
        read  = 1'b1;
        din   = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        chk("rst_rd_n", 32'(rd_n), 1);
        chk("rst_wr_n", 32'(wr_n), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_avail", 32'(avail), 0);
        chk("rst_tx_level", 32'(tx_level), 0);
        chk("rst_rx_level", 32'(rx_level), 0);
        write = 1'b0;
        read  = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        // Single word out: LSB first, 3 cycles apart, strobe one cycle after the push.
        txe_n = 1'b0;
        wr_cycs.delete();
        din   = 32'hA1B2_C3D4;
        write = 1'b1;
        push_tx_word(din);
        @(negedge clk);
        write = 1'b0;
        chk("tx_level_after_write", 32'(tx_level), 1);
        chk("tx_latency_idle", 32'(wr_n), 1);
        @(negedge clk);
        chk("tx_latency_strobe", 32'(wr_n), 0);
        k = 0;
        while (k < 20 && !(!wr_n && wr_cycs.size() == 3)) begin
            @(negedge clk);
            k++;
        end
        chk("tx_level_during_last", 32'(tx_level), 1);
        @(negedge clk);
        chk("tx_level_after_last", 32'(tx_level), 0);
        chk("tx_pulses", 32'(wr_cycs.size()), 4);
        if (wr_cycs.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("tx_spacing", 32'(wr_cycs[i] - wr_cycs[i-1]), 3);
        end

        // Single word in: 11 22 33 44 assemble to 0x44332211.
        push_rx_word(32'h4433_2211);
        rx_en = 1'b1;
        for (k = 0; k < 40 && !avail; k++) @(negedge clk);
        chk("rx_avail", 32'(avail), 1);
        chk("rx_latency", 32'(cyc), 32'(last_rd_cyc + 1));
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        chk("rx_avail_after_read", 32'(avail), 0);
        rx_en = 1'b0;

        // Both directions busy: strobes alternate, write first.
        txe_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din   = $urandom;
            write = 1'b1;
            push_tx_word(din);
            @(negedge clk);
        end
        write = 1'b0;
        push_rx_word($urandom);
        push_rx_word($urandom);
        @(negedge clk);
        strobe_log.delete();
        log_en = 1'b1;
        txe_n  = 1'b0;
        rx_en  = 1'b1;
        for (k = 0; k < 100 && strobe_log.size() < 16; k++) @(negedge clk);
        log_en = 1'b0;
        chk("alt_count", 32'(strobe_log.size()), 16);
        for (int i = 0; i < strobe_log.size() && i < 16; i++)
            chk("alt_seq", 32'(strobe_log[i]), (i % 2 == 0) ? 32'h57 : 32'h52);
        drain(300);

        // TX full: 16 words accepted, the 17th dropped.
        txe_n = 1'b1;
        rx_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            din   = $urandom;
            write = 1'b1;
            push_tx_word(din);
            @(negedge clk);
        end
        chk("tx_full_flag", 32'(full), 1);
        chk("tx_full_level", 32'(tx_level), DEPTH);
        din   = $urandom;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        chk("tx_overflow_level", 32'(tx_level), DEPTH);
        chk("tx_overflow_full", 32'(full), 1);

        // RX full: reads stop with a whole word still waiting in the chip.
        for (int i = 0; i <= DEPTH; i++) push_rx_word($urandom);
        rx_en = 1'b1;
        for (k = 0; k < 400 && rx_level != DEPTH; k++) @(negedge clk);
        chk("rx_full_level", 32'(rx_level), DEPTH);
        base = rd_cnt;
        repeat (12) @(negedge clk);
        chk("rx_blocked_strobes", 32'(rd_cnt), 32'(base));
        chk("rx_blocked_rd_n", 32'(rd_n), 1);
        chk("rx_blocked_chip", 32'(chip_q.size()), BYTES);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        for (k = 0; k < 40 && chip_q.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rx_resume_chip", 32'(chip_q.size()), 0);
        chk("rx_resume_level", 32'(rx_level), DEPTH);
        drain(1500);

        // Reset during the third RD strobe: partial word is discarded.
        txe_n = 1'b1;
        for (int b = 0; b < BYTES; b++) chip_q.push_back(8'hAA + 8'(b));
        rx_en = 1'b1;
        base  = rd_cnt;
        for (k = 0; k < 40 && !(!rd_n && rd_cnt == base + 2); k++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rd_n", 32'(rd_n), 1);
        chk("rst_mid_rx_level", 32'(rx_level), 0);
        rx_en = 1'b0;
        chip_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        push_rx_word(32'h8877_6655);
        rx_en = 1'b1;
        for (k = 0; k < 40 && !avail; k++) @(negedge clk);
        chk("rst_mid_avail", 32'(avail), 1);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_stale", 32'(avail), 0);
        chk("rst_mid_rx_level_end", 32'(rx_level), 0);

        // Randomised traffic against the scoreboards.
        tx_words_acc = tx_words_done;
        for (int c = 0; c < 3000; c++) begin
            txe_n = ($urandom_range(0, 9) < 3);
            rx_en = ($urandom_range(0, 9) < 8);
            write = 1'b0;
            if ((tx_words_acc - tx_words_done) < DEPTH - 2 && $urandom_range(0, 3) == 0) begin
                din   = $urandom;
                write = 1'b1;
                tx_words_acc++;
                push_tx_word(din);
            end
            if (chip_q.size() < 12 && $urandom_range(0, 5) == 0) begin
                w = $urandom;
                push_rx_word(w);
            end
            read = avail && ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        write = 1'b0;
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sp_usb_fifo_bridge.md
Name: sp_usb_fifo_bridge

Overview:
- Parametrised successor to the single-byte FT245-style USB sync bridge.
- Sits between the external 8-bit USB FIFO chip and kernel streams.
- Buffers DEPTH words in each direction and packs/unpacks WIDTH-bit words into little-endian byte sequences.
- Arbitrates fairly between host-read and host-write traffic.

Parameters:
- WIDTH, 32: stream word width in bits; must be a multiple of 8 and at least 8.
- DEPTH, 16: words per direction FIFO; power of two, at least 2.
- BYTES, WIDTH/8: derived constant; bytes per word.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous reset, active-low.
- usb_data  inout  8: USB chip data bus.
- rxf_n  in  1: low when the chip holds a byte for us.
- txe_n  in  1: low when the chip can accept a byte.
- rd_n  out  1: read strobe, active-low.
- wr_n  out  1: write strobe, active-low.
- din  in  WIDTH: word to send to the host.
- write  in  1: push din into the TX FIFO.
- full  out  1: TX FIFO full; writes are ignored while high.
- dout  out  WIDTH: head word of the RX FIFO.
- read  in  1: pop the RX FIFO.
- avail  out  1: RX FIFO non-empty; dout is valid.
- tx_level  out  $clog2(DEPTH)+1: TX FIFO occupancy.
- rx_level  out  $clog2(DEPTH)+1: RX FIFO occupancy.

Behaviour:
- Reset (rst==0 at posedge):
  - FIFOs emptied; partial TX/RX byte counters cleared and partial words discarded.
  - state=IDLE, rd_n=1, wr_n=1, usb_data=Z, full=0, avail=0, levels=0.
  - dout value is don't-care.
  - Reset mid-strobe deasserts the strobe at the next edge.
- FIFOs are first-word-fall-through with registered occupancy. Simultaneous push and pop is legal at any level:
  - when full, push is ignored and the pop proceeds;
  - when empty, the pop is ignored and the push proceeds.
- TX serializer:
  - Byte index tb counts 0..BYTES-1.
  - The byte sent is TX head bits [8*tb+7:8*tb], least significant byte first.
  - The head word is popped when the byte at tb=BYTES-1 completes; tb then wraps to 0.
- RX deserializer:
  - Byte index rb counts 0..BYTES-1; byte rb is written into the assembly register at [8*rb+7:8*rb].
  - The assembled word is pushed into the RX FIFO when byte BYTES-1 is captured.
- FSM states: IDLE, WR, RD, RECOVER.
  - tx_ok = TX FIFO non-empty and !txe_n.
  - rx_ok = !rxf_n and RX FIFO level < DEPTH.
  - IDLE -> WR if tx_ok and (!rx_ok or last_dir==RD).
  - IDLE -> RD if rx_ok and (!tx_ok or last_dir==WR).
  - Otherwise IDLE holds.
  - WR and RD last exactly one cycle, then go to RECOVER; RECOVER lasts one cycle, then returns to IDLE.
  - last_dir is updated on entry to WR/RD; its reset value is RD, so TX wins the first tie.
- Outputs per state:
  - WR: wr_n=0; usb_data driven from a byte register loaded on the IDLE->WR edge.
  - RD: rd_n=0; usb_data=Z; byte sampled at the RD->RECOVER edge.
  - All other states: both strobes high, usb_data=Z.
- Throughput: one byte per 3 cycles. With alternating traffic, each direction gets at least one byte per 6 cycles.
- TX latency: with an empty FIFO and txe_n low, write at edge t gives wr_n low during cycle t+1 (IDLE sees non-empty at t+1 and enters WR at t+1, so the strobe is seen after edge t+1).
- RX latency: the word appears on dout/avail the cycle after the final RD cycle.
- rx_ok requires a free RX slot even for non-final bytes. This guarantees a completed word is never dropped.
- txe_n or rxf_n changing during WR/RD does not abort the strobe.

Decomposition:
- Package sp_usb_pkg holds the FSM state constants and the DIR_RD/DIR_WR encodings.
- One sub-module, sp_sync_fifo (WIDTH, DEPTH; FWFT, level output, same clk/rst), instantiated twice.

Test Plan:
- Reset with rst=0 for 3 cycles while driving write/read -> strobes high, usb_data Z, full=0, avail=0, levels 0.
- WIDTH=32; write 0xA1B2C3D4; txe_n=0 -> usb_data sees bytes B1..B4 = D4, C3, B2, A1 on wr_n pulses 3 cycles apart; tx_level goes 1 -> 0 after the 4th byte.
- rxf_n=0 with chip bytes 11, 22, 33, 44 -> avail=1, dout=0x44332211 the cycle after the 4th rd_n pulse; read -> avail=0.
- tx_ok and rx_ok held true continuously -> strobe sequence WR, RD, WR, RD… (first is WR); no back-to-back same-direction strobes.
- Fill TX with DEPTH=16 words and txe_n=1 -> full=1 and tx_level=16; a 17th write is ignored. Fill RX to 16 with read=0 -> rd_n stays high despite rxf_n=0; read once -> reads resume.
- Pull rst low during the RD cycle after 2 of 4 bytes -> rd_n=1 next cycle, rx_level=0. After release, 4 new bytes form exactly one word; stale bytes do not appear.
